// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared definitions for the mac operand sequencer.
//   seq_state_e : sequencer FSM states (IDLE, ISSUE, WAIT, CAPT, OUT)
//   DATA_W      : operand width of the signed int8 mac inputs
//   ACC_W       : accumulator width of the mac result
//   N_MAX       : largest matrix dimension whose worst-case dot product
//                 still fits in ACC_W signed bits
package mac_seq_pkg;

    localparam int DATA_W = 32'd8;
    localparam int ACC_W  = 32'd19;
    localparam int N_MAX  = 32'd15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CAPT  = 3'd3,
        OUT   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/mac_seq_agen.sv
// mac_seq_agen: i/j/k loop counters and operand buffer address generation.
// Addresses are registered from the next-state counter values, so they are
// valid in the same cycle as the counters they describe.
//   clk, rst_n   : clock, synchronous active-low reset
//   clr          : zero all counters (start of a run)
//   k_inc        : step k, wrapping to 0 after N-1
//   j_adv        : step j, wrapping to 0 and stepping i after N-1
//   row_idx      : current i
//   col_idx      : current j
//   k_first      : k == 0
//   k_last       : k == N-1
//   elem_last    : (i, j) == (N-1, N-1)
//   a_addr       : i*N + k
//   b_addr       : k*N + j
module mac_seq_agen
    import mac_seq_pkg::*;
#(
    parameter int N  = 32'd4,
    parameter int AW = 32'd4,
    parameter int IW = 32'd2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          k_inc,
    input  logic          j_adv,
    output logic [IW-1:0] row_idx,
    output logic [IW-1:0] col_idx,
    output logic          k_first,
    output logic          k_last,
    output logic          elem_last,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 32'd1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(32'd1);
    localparam logic [AW-1:0] N_A      = AW'(N);

    logic [IW-1:0] i_r, j_r, k_r;
    logic [IW-1:0] i_nxt_s, j_nxt_s, k_nxt_s;
    logic [AW-1:0] a_addr_r, b_addr_r;

    assign row_idx   = i_r;
    assign col_idx   = j_r;
    assign k_first   = (k_r == {IW{1'b0}});
    assign k_last    = (k_r == LAST_IDX);
    assign elem_last = (i_r == LAST_IDX) && (j_r == LAST_IDX);
    assign a_addr    = a_addr_r;
    assign b_addr    = b_addr_r;

    // Next counter values; clear has priority, k and j never step together.
    always_comb begin
        i_nxt_s = i_r;
        j_nxt_s = j_r;
        k_nxt_s = k_r;
        if (clr) begin
            i_nxt_s = {IW{1'b0}};
            j_nxt_s = {IW{1'b0}};
            k_nxt_s = {IW{1'b0}};
        end else if (k_inc) begin
            if (k_r == LAST_IDX) begin
                k_nxt_s = {IW{1'b0}};
            end else begin
                k_nxt_s = k_r + IDX_ONE;
            end
        end else if (j_adv) begin
            if (j_r == LAST_IDX) begin
                j_nxt_s = {IW{1'b0}};
                if (i_r == LAST_IDX) begin
                    i_nxt_s = {IW{1'b0}};
                end else begin
                    i_nxt_s = i_r + IDX_ONE;
                end
            end else begin
                j_nxt_s = j_r + IDX_ONE;
            end
        end else begin
            k_nxt_s = k_r;
        end
    end

    // Counter and address registers; addresses track the next counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_r      <= {IW{1'b0}};
            j_r      <= {IW{1'b0}};
            k_r      <= {IW{1'b0}};
            a_addr_r <= {AW{1'b0}};
            b_addr_r <= {AW{1'b0}};
        end else begin
            i_r      <= i_nxt_s;
            j_r      <= j_nxt_s;
            k_r      <= k_nxt_s;
            a_addr_r <= AW'(i_nxt_s) * N_A + AW'(k_nxt_s);
            b_addr_r <= AW'(k_nxt_s) * N_A + AW'(j_nxt_s);
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: walks two NxN int8 matrices in synchronous-read buffers,
// streams operand pairs into an external mac, and returns each C[i][j] in
// row-major order over a valid/ready port.
//   clk, rst_n            : clock, synchronous active-low reset
//   start                 : begin a run (sampled only in IDLE)
//   busy, done            : run in progress / one-cycle completion pulse
//   a_rd_addr, a_rd_data  : A buffer address (i*N+k) and data (1-cycle latency)
//   b_rd_addr, b_rd_data  : B buffer address (k*N+j) and data
//   mac_A, mac_B          : operands to the mac, zero when no pair is valid
//   mac_clear             : restart accumulation on the first term
//   mac_C                 : accumulated sum from the mac
//   res_valid, res_ready  : result handshake
//   res_data, res_row, res_col : result value and its (i, j)
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int N  = 32'd4,
    parameter int AW = (N * N > 32'd1) ? $clog2(N * N) : 32'd1,
    parameter int IW = (N > 32'd1) ? $clog2(N) : 32'd1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [AW-1:0]            a_rd_addr,
    input  logic signed [DATA_W-1:0] a_rd_data,
    output logic [AW-1:0]            b_rd_addr,
    input  logic signed [DATA_W-1:0] b_rd_data,
    output logic signed [DATA_W-1:0] mac_A,
    output logic signed [DATA_W-1:0] mac_B,
    output logic                     mac_clear,
    input  logic signed [ACC_W-1:0]  mac_C,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [ACC_W-1:0]  res_data,
    output logic [IW-1:0]            res_row,
    output logic [IW-1:0]            res_col
);

    seq_state_e               state_r;
    logic                     busy_r, done_r;
    logic                     rd_v_r, rd_first_r;
    logic                     res_valid_r;
    logic signed [ACC_W-1:0]  res_data_r;
    logic [IW-1:0]            res_row_r, res_col_r;

    logic                     clr_s, k_inc_s, j_adv_s;
    logic [IW-1:0]            row_idx_s, col_idx_s;
    logic                     k_first_s, k_last_s, elem_last_s;

    mac_seq_agen #(
        .N  (N),
        .AW (AW),
        .IW (IW)
    ) u_agen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_s),
        .k_inc     (k_inc_s),
        .j_adv     (j_adv_s),
        .row_idx   (row_idx_s),
        .col_idx   (col_idx_s),
        .k_first   (k_first_s),
        .k_last    (k_last_s),
        .elem_last (elem_last_s),
        .a_addr    (a_rd_addr),
        .b_addr    (b_rd_addr)
    );

    assign busy      = busy_r;
    assign done      = done_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_row   = res_row_r;
    assign res_col   = res_col_r;

    // Buffer data is only forwarded in the cycle after an issue, so the mac
    // adds zero while waiting, capturing or stalled and C holds its value.
    assign mac_A     = rd_v_r ? a_rd_data : {DATA_W{1'b0}};
    assign mac_B     = rd_v_r ? b_rd_data : {DATA_W{1'b0}};
    assign mac_clear = rd_v_r & rd_first_r;

    // Counter controls decoded from the current state.
    always_comb begin
        clr_s   = 1'b0;
        k_inc_s = 1'b0;
        j_adv_s = 1'b0;
        case (state_r)
            IDLE:    clr_s   = start;
            ISSUE:   k_inc_s = 1'b1;
            OUT:     j_adv_s = res_valid_r & res_ready;
            default: clr_s   = 1'b0;
        endcase
    end

    // Sequencer FSM with registered status, operand-valid and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rd_v_r      <= 1'b0;
            rd_first_r  <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= {ACC_W{1'b0}};
            res_row_r   <= {IW{1'b0}};
            res_col_r   <= {IW{1'b0}};
        end else begin
            done_r     <= 1'b0;
            rd_v_r     <= 1'b0;
            rd_first_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        busy_r  <= 1'b1;
                        state_r <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Data for this address arrives next cycle, with its tag.
                    rd_v_r     <= 1'b1;
                    rd_first_r <= k_first_s;
                    if (k_last_s) begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    state_r <= CAPT;
                end
                CAPT: begin
                    res_data_r  <= mac_C;
                    res_row_r   <= row_idx_s;
                    res_col_r   <= col_idx_s;
                    res_valid_r <= 1'b1;
                    state_r     <= OUT;
                end
                OUT: begin
                    if (res_valid_r && res_ready) begin
                        res_valid_r <= 1'b0;
                        if (elem_last_s) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                        end else begin
                            state_r <= ISSUE;
                        end
                    end
                end
                default: begin
                    busy_r      <= 1'b0;
                    res_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: drives three sequencer instances (N=2, N=15, N=1), each
// with its own operand buffers and a behavioural mac, and checks results
// against a scoreboard of dot products computed from the loaded matrices.
module tb_mac_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic signed [7:0] ma [0:224];
    logic signed [7:0] mb [0:224];

    typedef struct { int d; int r; int c; } exp_t;
    exp_t sb_q [$];
    int err_cnt = 0;
    int chk_cnt = 0;

    // N=2 instance signals
    logic st2, busy2, done2, clr2, val2, rdy2;
    logic [1:0] aa2, ba2;
    logic signed [7:0] ad2, bd2, mA2, mB2;
    logic signed [15:0] p2;
    logic signed [18:0] C2, res2;
    logic [0:0] row2, col2;
    // N=15 instance signals
    logic st15, busy15, done15, clr15, val15, rdy15;
    logic [7:0] aa15, ba15;
    logic signed [7:0] ad15, bd15, mA15, mB15;
    logic signed [15:0] p15;
    logic signed [18:0] C15, res15;
    logic [3:0] row15, col15;
    // N=1 instance signals
    logic st1, busy1, done1, clr1, val1, rdy1;
    logic [0:0] aa1, ba1;
    logic signed [7:0] ad1, bd1, mA1, mB1;
    logic signed [15:0] p1;
    logic signed [18:0] C1, res1;
    logic [0:0] row1, col1;

    mac_sequencer #(.N(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .busy(busy2), .done(done2),
        .a_rd_addr(aa2), .a_rd_data(ad2), .b_rd_addr(ba2), .b_rd_data(bd2),
        .mac_A(mA2), .mac_B(mB2), .mac_clear(clr2), .mac_C(C2),
        .res_valid(val2), .res_ready(rdy2), .res_data(res2),
        .res_row(row2), .res_col(col2));

    mac_sequencer #(.N(15)) u15 (
        .clk(clk), .rst_n(rst_n), .start(st15), .busy(busy15), .done(done15),
        .a_rd_addr(aa15), .a_rd_data(ad15), .b_rd_addr(ba15), .b_rd_data(bd15),
        .mac_A(mA15), .mac_B(mB15), .mac_clear(clr15), .mac_C(C15),
        .res_valid(val15), .res_ready(rdy15), .res_data(res15),
        .res_row(row15), .res_col(col15));

    mac_sequencer #(.N(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .busy(busy1), .done(done1),
        .a_rd_addr(aa1), .a_rd_data(ad1), .b_rd_addr(ba1), .b_rd_data(bd1),
        .mac_A(mA1), .mac_B(mB1), .mac_clear(clr1), .mac_C(C1),
        .res_valid(val1), .res_ready(rdy1), .res_data(res1),
        .res_row(row1), .res_col(col1));

    assign p2  = mA2 * mB2;
    assign p15 = mA15 * mB15;
    assign p1  = mA1 * mB1;

    // Synchronous-read buffers and accumulating mac models (never reset).
    always @(posedge clk) begin
        ad2  <= ma[aa2];  bd2  <= mb[ba2];
        ad15 <= ma[aa15]; bd15 <= mb[ba15];
        ad1  <= ma[aa1];  bd1  <= mb[ba1];
        C2  <= clr2  ? {{3{p2[15]}}, p2}   : C2  + {{3{p2[15]}}, p2};
        C15 <= clr15 ? {{3{p15[15]}}, p15} : C15 + {{3{p15[15]}}, p15};
        C1  <= clr1  ? {{3{p1[15]}}, p1}   : C1  + {{3{p1[15]}}, p1};
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        chk_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pops the scoreboard for a result that will be accepted at the next edge.
    task automatic mon(input string tag, input logic v, input logic r,
                       input logic signed [18:0] d, input int row, input int col);
        exp_t e;
        if (v && r) begin
            chk_cnt++;
            assert (sb_q.size() != 0) else begin
                err_cnt++;
                $error("FAIL %s_unexpected observed=%0d expected=none", tag, d);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check({tag, "_data"}, d, e.d);
                check({tag, "_row"}, row, e.r);
                check({tag, "_col"}, col, e.c);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        mon("n2", val2, rdy2, res2, int'(row2), int'(col2));
        mon("n15", val15, rdy15, res15, int'(row15), int'(col15));
        mon("n1", val1, rdy1, res1, int'(row1), int'(col1));
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input int n);
        int s;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++) begin
                    s += int'(ma[i*n+k]) * int'(mb[k*n+j]);
                end
                sb_q.push_back('{d: s, r: i, c: j});
            end
        end
    endtask

    function automatic logic done_of(input int w);
        case (w)
            2:       return done2;
            15:      return done15;
            default: return done1;
        endcase
    endfunction

    function automatic logic valid_of(input int w);
        case (w)
            2:       return val2;
            15:      return val15;
            default: return val1;
        endcase
    endfunction

    // Pulses start; returns in the first cycle after start is sampled.
    task automatic start_run(input int w);
        case (w)
            2:       st2 = 1'b1;
            15:      st15 = 1'b1;
            default: st1 = 1'b1;
        endcase
        step();
        st2 = 1'b0; st15 = 1'b0; st1 = 1'b0;
    endtask

    // Steps until done (bounded); cycle indices count the first issue as 1.
    task automatic run_wait(input int w, input int n0, input int bound,
                            output int done_at, output int valid_at);
        int n;
        n = n0;
        valid_at = 0;
        while (!done_of(w) && n < bound) begin
            if (valid_at == 0 && valid_of(w)) valid_at = n;
            step();
            n++;
        end
        done_at = n;
    endtask

    task automatic check_zero2(input string tag);
        check({tag, "_busy"}, busy2, 0);
        check({tag, "_done"}, done2, 0);
        check({tag, "_a_addr"}, aa2, 0);
        check({tag, "_b_addr"}, ba2, 0);
        check({tag, "_clear"}, clr2, 0);
        check({tag, "_valid"}, val2, 0);
        check({tag, "_data"}, res2, 0);
        check({tag, "_row"}, row2, 0);
        check({tag, "_col"}, col2, 0);
        check({tag, "_mac_A"}, mA2, 0);
        check({tag, "_mac_B"}, mB2, 0);
    endtask

    initial begin
        int n, d_at, v_at;
        logic signed [18:0] hold_d, hold_c;
        logic [1:0] hold_a, hold_b;

        rst_n = 1'b0;
        st2 = 1'b0; st15 = 1'b0; st1 = 1'b0;
        rdy2 = 1'b1; rdy15 = 1'b1; rdy1 = 1'b1;
        for (int i = 0; i < 225; i++) begin
            ma[i] = 8'sd0;
            mb[i] = 8'sd0;
        end
        repeat (3) step();
        check_zero2("reset");
        rst_n = 1'b1;
        step();

        // Basic 2x2: results 19, 22, 43, 50
        ma[0] = 8'sd1; ma[1] = 8'sd2; ma[2] = 8'sd3; ma[3] = 8'sd4;
        mb[0] = 8'sd5; mb[1] = 8'sd6; mb[2] = 8'sd7; mb[3] = 8'sd8;
        push_expected(2);
        start_run(2);
        check("first_a_addr", aa2, 0);
        check("first_b_addr", ba2, 0);
        check("first_busy", busy2, 1);
        step();
        check("first_clear", clr2, 1);
        check("first_mac_A", mA2, 1);
        check("first_mac_B", mB2, 5);
        step();
        check("second_clear", clr2, 0);
        check("second_mac_A", mA2, 2);
        check("second_mac_B", mB2, 7);
        run_wait(2, 3, 60, d_at, v_at);
        check("basic_valid_cycle", v_at, 5);
        check("basic_done_cycle", d_at, 21);
        check("basic_done_busy", busy2, 0);
        check("basic_sb_empty", sb_q.size(), 0);
        step();
        check("basic_done_pulse", done2, 0);

        // Backpressure on the first result
        rdy2 = 1'b0;
        ma[0] = 8'sd2;  ma[1] = -8'sd3; ma[2] = 8'sd5; ma[3] = 8'sd7;
        mb[0] = -8'sd1; mb[1] = 8'sd4;  mb[2] = 8'sd6; mb[3] = -8'sd8;
        push_expected(2);
        start_run(2);
        n = 1;
        while (!val2 && n < 20) begin
            step();
            n++;
        end
        check("bp_valid_cycle", n, 5);
        hold_d = res2; hold_c = C2; hold_a = aa2; hold_b = ba2;
        for (int s = 1; s <= 4; s++) begin
            step();
            n++;
            check("bp_valid_held", val2, 1);
            check("bp_data_held", res2, hold_d);
            check("bp_mac_C_held", C2, hold_c);
            check("bp_a_addr_held", aa2, hold_a);
            check("bp_b_addr_held", ba2, hold_b);
        end
        step();
        n++;
        rdy2 = 1'b1;
        check("bp_still_valid", val2, 1);
        step();
        n++;
        check("bp_accepted", val2, 0);
        check("bp_resume_a_addr", aa2, 0);
        check("bp_resume_b_addr", ba2, 1);
        run_wait(2, n, 80, d_at, v_at);
        check("bp_done_cycle", d_at, 26);
        check("bp_sb_empty", sb_q.size(), 0);
        step();

        // Start asserted mid-ISSUE (cycle 2) and mid-OUT (cycle 5)
        push_expected(2);
        start_run(2);
        n = 1;
        while (!done2 && n < 60) begin
            st2 = (n == 2 || n == 5);
            step();
            n++;
        end
        st2 = 1'b0;
        check("restart_done_cycle", n, 21);
        check("restart_sb_empty", sb_q.size(), 0);
        step();
        check("restart_idle_busy", busy2, 0);

        // Reset while issuing k=1, then a clean run
        start_run(2);
        step();
        rst_n = 1'b0;
        step();
        check_zero2("midrst");
        rst_n = 1'b1;
        ma[0] = -8'sd1; ma[1] = 8'sd2;  ma[2] = 8'sd3;  ma[3] = -8'sd4;
        mb[0] = 8'sd9;  mb[1] = -8'sd2; mb[2] = 8'sd5;  mb[3] = 8'sd1;
        push_expected(2);
        start_run(2);
        run_wait(2, 1, 60, d_at, v_at);
        check("post_rst_done_cycle", d_at, 21);
        check("post_rst_sb_empty", sb_q.size(), 0);
        step();

        // N=15 extremes: 245760 then -243840 everywhere
        for (int i = 0; i < 225; i++) begin
            ma[i] = -8'sd128;
            mb[i] = -8'sd128;
        end
        push_expected(15);
        start_run(15);
        run_wait(15, 1, 6000, d_at, v_at);
        check("n15_neg_done_cycle", d_at, 4051);
        check("n15_neg_sb_empty", sb_q.size(), 0);
        step();
        for (int i = 0; i < 225; i++) mb[i] = 8'sd127;
        push_expected(15);
        start_run(15);
        run_wait(15, 1, 6000, d_at, v_at);
        check("n15_mix_done_cycle", d_at, 4051);
        check("n15_mix_sb_empty", sb_q.size(), 0);
        step();

        // Degenerate N=1: single result -63
        ma[0] = -8'sd7;
        mb[0] = 8'sd9;
        push_expected(1);
        start_run(1);
        run_wait(1, 1, 30, d_at, v_at);
        check("n1_valid_cycle", v_at, 4);
        check("n1_done_cycle", d_at, 5);
        check("n1_sb_empty", sb_q.size(), 0);
        step();
        check("n1_done_pulse", done1, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
